// File: rtl/entrada_dos_digitos_pkg.sv
// Purpose : shared types and constants for the two-digit BCD entry block.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: FSM state encoding, decimal constants, combination width and a
// shift-add helper that turns a tens/units pair into its binary value.
package entrada_dos_digitos_pkg;

  typedef enum logic [1:0] {
    ESPERA_DECENAS  = 2'd0,
    ESPERA_UNIDADES = 2'd1,
    ENTREGA         = 2'd2
  } estado_t;

  localparam int BASE_DECIMAL      = 10;
  localparam int VALOR_MAXIMO      = 99;
  localparam int ANCHO_COMBINACION = 7;

  // Largest legal BCD digit; anything above is rejected at the input.
  localparam logic [3:0] DIGITO_MAXIMO = 4'(BASE_DECIMAL - 1);

  // tens*10 + units built as (tens<<3)+(tens<<1)+units. With legal digits the
  // result never exceeds VALOR_MAXIMO, so 7 bits are always enough.
  function automatic logic [ANCHO_COMBINACION-1:0] combina_digitos(
    input logic [3:0] decenas,
    input logic [3:0] unidades
  );
    logic [ANCHO_COMBINACION-1:0] w_por8;
    logic [ANCHO_COMBINACION-1:0] w_por2;
    logic [ANCHO_COMBINACION-1:0] w_unid;
    w_por8 = {decenas, 3'b000};
    w_por2 = {2'b00, decenas, 1'b0};
    w_unid = {3'b000, unidades};
    return w_por8 + w_por2 + w_unid;
  endfunction

endpackage

// File: rtl/entrada_dos_digitos_contador.sv
// Purpose : cycle counter that flags when the units digit has waited too long.
// Latency : o_expira is combinational from the counter register.
// Backpr. : none; counts while i_habilitar is high, holds at the limit.
//
// Ports: clk, reset (sync, active high), i_limpiar (restart from zero),
//        i_habilitar (count this cycle), o_expira (count == TIMEOUT_CICLOS-1).
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_limpiar,
  input  logic i_habilitar,
  output logic o_expira
);

  localparam int ANCHO = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [ANCHO-1:0] LIMITE = ANCHO'(TIMEOUT_CICLOS - 1);

  logic [ANCHO-1:0] r_cuenta;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cuenta <= '0;
    end else if (i_limpiar) begin
      r_cuenta <= '0;
    end else if (i_habilitar && (r_cuenta != LIMITE)) begin
      // Saturate at the limit so the counter can never wrap back to zero.
      r_cuenta <= r_cuenta + ANCHO'(1);
    end
  end

  assign o_expira = (r_cuenta == LIMITE);

endmodule

// File: rtl/entrada_dos_digitos.sv
// Purpose : collects a tens then a units BCD digit and outputs their binary value.
// Latency : combinacion/combinacion_valida appear one cycle after the units edge.
// Backpr. : listo=0 for the single ENTREGA cycle; digits offered then are dropped.
//
// Ports: clk, reset (sync, active high), digito_valido/digito (BCD input),
//        borrar (abort entry), listo (digit accepted this cycle),
//        combinacion[6:0] (last completed value), combinacion_valida,
//        error_digito, expirado (one-cycle status pulses).
module entrada_dos_digitos
  import entrada_dos_digitos_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         digito_valido,
  input  logic [3:0]                   digito,
  input  logic                         borrar,
  output logic                         listo,
  output logic [ANCHO_COMBINACION-1:0] combinacion,
  output logic                         combinacion_valida,
  output logic                         error_digito,
  output logic                         expirado
);

  estado_t                      r_estado;
  estado_t                      w_estado_sig;
  logic [3:0]                   r_decenas;
  logic [ANCHO_COMBINACION-1:0] r_combinacion;
  logic                         r_combinacion_valida;
  logic                         r_error_digito;
  logic                         r_expirado;

  logic w_listo;
  logic w_intento;
  logic w_ilegal;
  logic w_acepta;
  logic w_rechaza;
  logic w_en_decenas;
  logic w_en_unidades;
  logic w_completa;
  logic w_cont_expira;
  logic w_expira;

  assign w_listo       = (r_estado != ENTREGA);
  assign w_en_decenas  = (r_estado == ESPERA_DECENAS);
  assign w_en_unidades = (r_estado == ESPERA_UNIDADES);

  // borrar outranks any digit presented in the same cycle.
  assign w_intento  = w_listo & digito_valido & ~borrar;
  assign w_ilegal   = (digito > DIGITO_MAXIMO);
  assign w_acepta   = w_intento & ~w_ilegal;
  assign w_rechaza  = w_intento & w_ilegal;
  assign w_completa = w_en_unidades & w_acepta;

  // A units digit on the expiry cycle wins; a rejected digit freezes the
  // state, so the expiry is simply re-evaluated on the following cycle.
  assign w_expira = w_en_unidades & w_cont_expira & ~borrar & ~w_acepta & ~w_rechaza;

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_contador (
    .clk        (clk),
    .reset      (reset),
    .i_limpiar  (w_en_decenas & w_acepta),
    .i_habilitar(w_en_unidades & ~w_rechaza),
    .o_expira   (w_cont_expira)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= ESPERA_DECENAS;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    if (borrar) begin
      w_estado_sig = ESPERA_DECENAS;
    end else begin
      unique case (r_estado)
        ESPERA_DECENAS: begin
          if (w_acepta) w_estado_sig = ESPERA_UNIDADES;
        end
        ESPERA_UNIDADES: begin
          if (w_acepta)      w_estado_sig = ENTREGA;
          else if (w_expira) w_estado_sig = ESPERA_DECENAS;
        end
        ENTREGA: begin
          w_estado_sig = ESPERA_DECENAS;
        end
        default: begin
          w_estado_sig = ESPERA_DECENAS;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_decenas            <= '0;
      r_combinacion        <= '0;
      r_combinacion_valida <= 1'b0;
      r_error_digito       <= 1'b0;
      r_expirado           <= 1'b0;
    end else begin
      r_combinacion_valida <= w_completa;
      r_error_digito       <= w_rechaza;
      r_expirado           <= w_expira;

      // Abort and timeout both throw away the partial entry.
      if (borrar || w_expira) begin
        r_decenas <= '0;
      end else if (w_en_decenas && w_acepta) begin
        r_decenas <= digito;
      end

      if (w_completa) begin
        r_combinacion <= combina_digitos(r_decenas, digito);
      end
    end
  end

  assign listo              = w_listo;
  assign combinacion        = r_combinacion;
  assign combinacion_valida = r_combinacion_valida;
  assign error_digito       = r_error_digito;
  assign expirado           = r_expirado;

endmodule

// File: tb/tb_entrada_dos_digitos.sv
module tb_entrada_dos_digitos;

  localparam int T = 8;

  logic       clk;
  logic       reset;
  logic       digito_valido;
  logic [3:0] digito;
  logic       borrar;
  logic       listo;
  logic [6:0] combinacion;
  logic       combinacion_valida;
  logic       error_digito;
  logic       expirado;

  int n_checks = 0;
  int n_errors = 0;

  entrada_dos_digitos #(
    .TIMEOUT_CICLOS(T)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .digito_valido     (digito_valido),
    .digito            (digito),
    .borrar            (borrar),
    .listo             (listo),
    .combinacion       (combinacion),
    .combinacion_valida(combinacion_valida),
    .error_digito      (error_digito),
    .expirado          (expirado)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    digito_valido = 1'b1;
    digito        = d;
    tick();
    digito_valido = 1'b0;
    digito        = 4'd0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    digito_valido = 1'b1;
    digito        = 4'd6;
    tick();
    tick();
    n_checks++;
    if (combinacion !== 7'd0) begin n_errors++; $display("FAIL reset_comb: got %0d expected 0", combinacion); end
    n_checks++;
    if ({combinacion_valida, error_digito, expirado} !== 3'b000) begin
      n_errors++; $display("FAIL reset_pulses: got %b expected 000", {combinacion_valida, error_digito, expirado});
    end
    n_checks++;
    if (listo !== 1'b1) begin n_errors++; $display("FAIL reset_listo: got %b expected 1", listo); end
    digito_valido = 1'b0;
    digito        = 4'd0;
    reset         = 1'b0;
    tick();
    n_checks++;
    if (listo !== 1'b1 || combinacion_valida !== 1'b0) begin
      n_errors++; $display("FAIL reset_release: listo=%b valida=%b expected 1 0", listo, combinacion_valida);
    end
  endtask

  task automatic test_basico();
    send(4'd6);
    n_checks++;
    if (combinacion_valida !== 1'b0 || listo !== 1'b1) begin
      n_errors++; $display("FAIL basico_tens: valida=%b listo=%b expected 0 1", combinacion_valida, listo);
    end
    send(4'd4);
    n_checks++;
    if (combinacion !== 7'd64) begin n_errors++; $display("FAIL basico_64: got %0d expected 64", combinacion); end
    n_checks++;
    if (combinacion_valida !== 1'b1 || listo !== 1'b0) begin
      n_errors++; $display("FAIL basico_entrega: valida=%b listo=%b expected 1 0", combinacion_valida, listo);
    end
    tick();
    n_checks++;
    if (combinacion_valida !== 1'b0 || listo !== 1'b1 || combinacion !== 7'd64) begin
      n_errors++; $display("FAIL basico_hold: valida=%b listo=%b comb=%0d expected 0 1 64",
                           combinacion_valida, listo, combinacion);
    end
  endtask

  task automatic test_limites();
    int tabla [3][3] = '{'{9, 9, 99}, '{0, 0, 0}, '{6, 3, 63}};
    for (int i = 0; i < 3; i++) begin
      send(4'(tabla[i][0]));
      send(4'(tabla[i][1]));
      n_checks++;
      if (combinacion !== 7'(tabla[i][2]) || combinacion_valida !== 1'b1) begin
        n_errors++; $display("FAIL limites_%0d: comb=%0d valida=%b expected %0d 1",
                             i, combinacion, combinacion_valida, tabla[i][2]);
      end
      tick();
    end
  endtask

  task automatic test_entrega_ignora();
    send(4'd1);
    send(4'd8);
    n_checks++;
    if (combinacion !== 7'd18) begin n_errors++; $display("FAIL entrega_18: got %0d expected 18", combinacion); end
    // Now in ENTREGA: this digit must be dropped silently.
    digito_valido = 1'b1;
    digito        = 4'd5;
    tick();
    digito_valido = 1'b0;
    n_checks++;
    if (error_digito !== 1'b0 || combinacion_valida !== 1'b0 || listo !== 1'b1) begin
      n_errors++; $display("FAIL entrega_ignora: err=%b valida=%b listo=%b expected 0 0 1",
                           error_digito, combinacion_valida, listo);
    end
    send(4'd2);
    n_checks++;
    if (combinacion_valida !== 1'b0) begin n_errors++; $display("FAIL entrega_tens: valida=%b expected 0", combinacion_valida); end
    send(4'd1);
    n_checks++;
    if (combinacion !== 7'd21) begin n_errors++; $display("FAIL entrega_21: got %0d expected 21", combinacion); end
    tick();
  endtask

  task automatic test_digito_ilegal();
    send(4'd12);
    n_checks++;
    if (error_digito !== 1'b1 || listo !== 1'b1 || combinacion_valida !== 1'b0) begin
      n_errors++; $display("FAIL ilegal_decenas: err=%b listo=%b valida=%b expected 1 1 0",
                           error_digito, listo, combinacion_valida);
    end
    tick();
    n_checks++;
    if (error_digito !== 1'b0) begin n_errors++; $display("FAIL ilegal_pulso: err=%b expected 0", error_digito); end
    send(4'd7);
    send(4'd1);
    n_checks++;
    if (combinacion !== 7'd71) begin n_errors++; $display("FAIL ilegal_71: got %0d expected 71", combinacion); end
    tick();
    send(4'd8);
    send(4'd13);
    n_checks++;
    if (error_digito !== 1'b1 || combinacion_valida !== 1'b0 || combinacion !== 7'd71) begin
      n_errors++; $display("FAIL ilegal_unidades: err=%b valida=%b comb=%0d expected 1 0 71",
                           error_digito, combinacion_valida, combinacion);
    end
    send(4'd2);
    n_checks++;
    if (combinacion !== 7'd82 || combinacion_valida !== 1'b1) begin
      n_errors++; $display("FAIL ilegal_82: comb=%0d valida=%b expected 82 1", combinacion, combinacion_valida);
    end
    tick();
  endtask

  task automatic test_timeout();
    send(4'd5);
    for (int k = 1; k < T; k++) begin
      tick();
      n_checks++;
      if (expirado !== 1'b0 || listo !== 1'b1) begin
        n_errors++; $display("FAIL timeout_antes_%0d: exp=%b listo=%b expected 0 1", k, expirado, listo);
      end
    end
    tick();
    n_checks++;
    if (expirado !== 1'b1 || combinacion !== 7'd82 || combinacion_valida !== 1'b0) begin
      n_errors++; $display("FAIL timeout_expira: exp=%b comb=%0d valida=%b expected 1 82 0",
                           expirado, combinacion, combinacion_valida);
    end
    tick();
    n_checks++;
    if (expirado !== 1'b0) begin n_errors++; $display("FAIL timeout_pulso: exp=%b expected 0", expirado); end
    send(4'd2);
    n_checks++;
    if (combinacion_valida !== 1'b0) begin n_errors++; $display("FAIL timeout_tens: valida=%b expected 0", combinacion_valida); end
    send(4'd8);
    n_checks++;
    if (combinacion !== 7'd28) begin n_errors++; $display("FAIL timeout_28: got %0d expected 28", combinacion); end
    tick();
    // Units digit landing on the expiry edge completes the entry.
    send(4'd5);
    for (int k = 1; k < T; k++) tick();
    send(4'd9);
    n_checks++;
    if (combinacion !== 7'd59 || combinacion_valida !== 1'b1 || expirado !== 1'b0) begin
      n_errors++; $display("FAIL timeout_gana: comb=%0d valida=%b exp=%b expected 59 1 0",
                           combinacion, combinacion_valida, expirado);
    end
    tick();
  endtask

  task automatic test_borrar();
    send(4'd3);
    borrar        = 1'b1;
    digito_valido = 1'b1;
    digito        = 4'd2;
    tick();
    borrar        = 1'b0;
    digito_valido = 1'b0;
    n_checks++;
    if (combinacion_valida !== 1'b0 || combinacion !== 7'd59 || listo !== 1'b1) begin
      n_errors++; $display("FAIL borrar: valida=%b comb=%0d listo=%b expected 0 59 1",
                           combinacion_valida, combinacion, listo);
    end
    send(4'd7);
    n_checks++;
    if (combinacion_valida !== 1'b0) begin n_errors++; $display("FAIL borrar_tens: valida=%b expected 0", combinacion_valida); end
    send(4'd7);
    n_checks++;
    if (combinacion !== 7'd77) begin n_errors++; $display("FAIL borrar_77: got %0d expected 77", combinacion); end
    tick();
  endtask

  task automatic test_reset_parcial();
    send(4'd4);
    reset = 1'b1;
    tick();
    n_checks++;
    if ({combinacion, combinacion_valida, error_digito, expirado} !== 10'd0 || listo !== 1'b1) begin
      n_errors++; $display("FAIL reset_parcial: comb=%0d valida=%b err=%b exp=%b listo=%b expected 0 0 0 0 1",
                           combinacion, combinacion_valida, error_digito, expirado, listo);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (listo !== 1'b1 || combinacion_valida !== 1'b0) begin
      n_errors++; $display("FAIL reset_parcial_release: listo=%b valida=%b expected 1 0", listo, combinacion_valida);
    end
    send(4'd4);
    n_checks++;
    if (combinacion_valida !== 1'b0) begin n_errors++; $display("FAIL reset_parcial_tens: valida=%b expected 0", combinacion_valida); end
    send(4'd2);
    n_checks++;
    if (combinacion !== 7'd42 || combinacion_valida !== 1'b1) begin
      n_errors++; $display("FAIL reset_parcial_42: comb=%0d valida=%b expected 42 1", combinacion, combinacion_valida);
    end
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    digito_valido = 1'b0;
    digito        = 4'd0;
    borrar        = 1'b0;
    test_reset();
    test_basico();
    test_limites();
    test_entrega_ignora();
    test_digito_ilegal();
    test_timeout();
    test_borrar();
    test_reset_parcial();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/entrada_dos_digitos.md
ENTRADA_DOS_DIGITOS -- requirements
Module: entrada_dos_digitos

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be named clk and the reset port reset.
REQ-002 Parameter: TIMEOUT_CICLOS, default 1000, max cycles allowed between tens and units digit.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: digito_valido  input  1  digito is presented this cycle.
REQ-006 Port: digito  input  4  BCD digit, legal 0..9.
REQ-007 Port: borrar  input  1  abort the entry in progress.
REQ-008 Port: listo  output  1  block accepts a digit this cycle.
REQ-009 Port: combinacion  output  7  last completed two-digit value, binary 0..99, feeds the >63 comparator.
REQ-010 Port: combinacion_valida  output  1  one-cycle pulse, combinacion just updated.
REQ-011 Port: error_digito  output  1  one-cycle pulse, illegal digit rejected.
REQ-012 Port: expirado  output  1  one-cycle pulse, entry discarded by timeout.

Function
REQ-013 The FSM SHALL have states ESPERA_DECENAS, ESPERA_UNIDADES and ENTREGA.
REQ-014 listo SHALL be 1 in ESPERA_DECENAS and ESPERA_UNIDADES and 0 in ENTREGA.
REQ-015 A digit SHALL be accepted at a rising edge where listo=1, digito_valido=1, borrar=0 and digito<=9.
REQ-016 In ESPERA_DECENAS an accepted digit SHALL be stored as tens, and the FSM SHALL go to ESPERA_UNIDADES.
REQ-017 In ESPERA_UNIDADES an accepted digit SHALL produce combinacion = tens*10 + units at the same edge, combinacion_valida=1 for the following cycle, and FSM -> ENTREGA.
REQ-018 Latency SHALL be one cycle: the value is visible in the cycle right after the edge that accepts the units digit.
REQ-019 ENTREGA SHALL last exactly one cycle, then -> ESPERA_DECENAS; digito_valido during ENTREGA SHALL be ignored without error.
REQ-020 The product tens*10 SHALL be computed as (tens<<3)+(tens<<1) with no multiplier; the result SHALL be held in 7 bits without overflow, max 99.
REQ-021 digito>9 with digito_valido=1 and listo=1 SHALL be rejected: state, tens and timeout counter unchanged, error_digito=1 the next cycle.
REQ-022 borrar=1 SHALL force ESPERA_DECENAS at the next edge from any state, discard stored tens, leave combinacion unchanged, and take priority over a simultaneous digit.
REQ-023 The timeout counter SHALL clear on entry to ESPERA_UNIDADES and increment each cycle there; when it reaches TIMEOUT_CICLOS-1 without an accepted digit, the FSM SHALL go to ESPERA_DECENAS and pulse expirado.
REQ-024 A units digit accepted on the expiry cycle SHALL win: the entry completes and expirado stays 0.
REQ-025 combinacion SHALL hold its value between completed entries.

Reset
REQ-026 reset SHALL take priority over all inputs: state=ESPERA_DECENAS, tens=0, counter=0, combinacion=0, combinacion_valida=0, error_digito=0, expirado=0.
REQ-027 reset asserted mid-entry SHALL discard the partial entry with no output pulse; listo=1 in the first cycle after reset is released.

Structure
REQ-028 A shared package SHALL hold the state encoding, the constant BASE_DECIMAL=10, the constant VALOR_MAXIMO=99 and the width constant ANCHO_COMBINACION=7.
REQ-029 The timeout counter SHALL be one sub-module, contador_timeout, with clear, enable and expiry ports, parameterised by TIMEOUT_CICLOS.

Verification
REQ-030 Digits 6, then 4 -> combinacion=64, combinacion_valida pulses 1 cycle, listo=0 that cycle.
REQ-031 Digits 9, 9 -> 99; digits 0, 0 -> 0; digits 6, 3 -> 63 (comparator boundary).
REQ-032 Digit 12 in ESPERA_DECENAS -> error_digito pulse, state unchanged; then 7, 1 -> 71.
REQ-033 Digit 5, then idle for TIMEOUT_CICLOS cycles -> expirado pulse, combinacion unchanged; units on the expiry cycle -> completes.
REQ-034 Digit 3 then borrar together with digit 2 -> ESPERA_DECENAS, no pulse, combinacion unchanged.
REQ-035 reset asserted after the tens digit -> all outputs 0; next entry 4, 2 -> 42.
